// File: rtl/ula_muldiv_ctrl_if.sv
// ---------------------------------------------------------------------------
// ula_muldiv_ctrl_if
// Bundles the execute-stage request (start, ALUOp, funct, op_a, op_b) and the
// decode / multiply-divide results of ula_muldiv_ctrl.
//   master : the pipeline side, drives the request, observes the results
//   slave  : the controller side, observes the request, drives the results
// ---------------------------------------------------------------------------
interface ula_muldiv_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       ALUOp;
    logic [5:0]       funct;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [3:0]       ALUControl;
    logic             illegal;
    logic             hilo_rd;
    logic [WIDTH-1:0] hilo_out;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, ALUOp, funct, op_a, op_b,
        input  ALUControl, illegal, hilo_rd, hilo_out,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start, ALUOp, funct, op_a, op_b,
        output ALUControl, illegal, hilo_rd, hilo_out,
        output busy, done, div_zero, hi, lo
    );
endinterface

// File: rtl/ula_muldiv_ctrl.sv
// ---------------------------------------------------------------------------
// ula_muldiv_ctrl
// ALU control decoder plus an iterative multiply/divide engine owning the
// architectural HI/LO registers.
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   bus        slave modport of ula_muldiv_ctrl_if:
//     start/ALUOp/funct/op_a/op_b           request from execute
//     ALUControl/illegal/hilo_rd/hilo_out   combinational decode results
//     busy/done/div_zero/hi/lo              engine status and HI/LO
// Multiply: shift-add on magnitudes, one multiplier bit per cycle.
// Divide:   restoring division on magnitudes, one quotient bit per cycle.
// Signs are restored in the FIN state.
// ---------------------------------------------------------------------------
module ula_muldiv_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    ula_muldiv_ctrl_if.slave  bus
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_FIN  = 2'b10;

    localparam logic [5:0] F_MFHI = 6'b010000;
    localparam logic [5:0] F_MTHI = 6'b010001;
    localparam logic [5:0] F_MFLO = 6'b010010;
    localparam logic [5:0] F_MTLO = 6'b010011;

    // Magnitude of a value when it is interpreted as signed
    function automatic logic [WIDTH-1:0] f_mag(input logic [WIDTH-1:0] v, input logic sgn);
        logic [WIDTH-1:0] m;
        if (sgn && v[WIDTH-1]) begin
            m = -v;
        end else begin
            m = v;
        end
        return m;
    endfunction

    logic [1:0]         r_state;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_acc;      // product upper half / partial remainder / div-by-zero dividend
    logic [WIDTH-1:0]   r_shf;      // multiplier shifting out, product lower half / quotient shifting in
    logic [WIDTH-1:0]   r_opb;      // multiplicand or divisor magnitude
    logic               r_is_div;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_dz_pend;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;
    logic               r_div_zero;

    logic               w_accept;
    logic               w_is_muldiv;
    logic               w_is_signed;
    logic               w_dz;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_div_shift;
    logic [WIDTH:0]     w_div_diff;
    logic               w_div_ge;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_res_hi;
    logic [WIDTH-1:0]   w_res_lo;
    logic [3:0]         w_alu_ctrl;
    logic               w_illegal;
    logic               w_hilo_rd;
    logic [WIDTH-1:0]   w_hilo_out;

    assign w_accept    = bus.start && (r_state == S_IDLE) && (bus.ALUOp == 4'b0000);
    assign w_is_muldiv = (bus.funct[5:2] == 4'b0110);
    assign w_is_signed = ~bus.funct[0];
    assign w_dz        = w_is_muldiv && bus.funct[1] && (bus.op_b == {WIDTH{1'b0}});

    // One shift-add step: add the multiplicand when the current multiplier bit is 1
    assign w_mul_sum   = {1'b0, r_acc} + (r_shf[0] ? {1'b0, r_opb} : {(WIDTH+1){1'b0}});
    // One restoring step: the remainder is always below the divisor, so the
    // sign bit of the (WIDTH+1)-bit difference is an exact borrow
    assign w_div_shift = {r_acc, r_shf[WIDTH-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_opb};
    assign w_div_ge    = ~w_div_diff[WIDTH];
    assign w_prod      = {r_acc, r_shf};

    // Sign fix-up of the finished magnitude result
    always_comb begin
        w_prod_fix = w_prod;
        w_res_hi   = r_acc;
        w_res_lo   = r_shf;
        if (r_is_div) begin
            w_res_lo = r_neg_q ? -r_shf : r_shf;
            w_res_hi = r_neg_r ? -r_acc : r_acc;
        end else begin
            w_prod_fix = r_neg_q ? -w_prod : w_prod;
            w_res_hi   = w_prod_fix[2*WIDTH-1:WIDTH];
            w_res_lo   = w_prod_fix[WIDTH-1:0];
        end
    end

    // ALUOp/funct to ULA operation code decode
    always_comb begin
        w_alu_ctrl = 4'b0010;
        w_illegal  = 1'b0;
        if (bus.ALUOp == 4'b0000) begin
            case (bus.funct)
                6'b000000: w_alu_ctrl = 4'b1001;
                6'b000010: w_alu_ctrl = 4'b1010;
                6'b000011: w_alu_ctrl = 4'b1101;
                6'b000100: w_alu_ctrl = 4'b0011;
                6'b000110: w_alu_ctrl = 4'b0100;
                6'b000111: w_alu_ctrl = 4'b0101;
                6'b100000: w_alu_ctrl = 4'b0010;
                6'b100010: w_alu_ctrl = 4'b0110;
                6'b100100: w_alu_ctrl = 4'b0000;
                6'b100101: w_alu_ctrl = 4'b0001;
                6'b100110: w_alu_ctrl = 4'b1011;
                6'b100111: w_alu_ctrl = 4'b1100;
                6'b101010: w_alu_ctrl = 4'b0111;
                6'b101011: w_alu_ctrl = 4'b1111;
                6'b010000, 6'b010001, 6'b010010, 6'b010011,
                6'b011000, 6'b011001, 6'b011010, 6'b011011: w_alu_ctrl = 4'b0010;
                default: begin
                    w_alu_ctrl = 4'b0010;
                    w_illegal  = 1'b1;
                end
            endcase
        end else begin
            case (bus.ALUOp)
                4'b0100: w_alu_ctrl = 4'b0110;
                4'b0101: w_alu_ctrl = 4'b1000;
                4'b1000: w_alu_ctrl = 4'b0010;
                4'b1010: w_alu_ctrl = 4'b0111;
                4'b1011: w_alu_ctrl = 4'b1111;
                4'b1100: w_alu_ctrl = 4'b0000;
                4'b1101: w_alu_ctrl = 4'b0001;
                4'b1110: w_alu_ctrl = 4'b1011;
                default: w_alu_ctrl = 4'b0010;
            endcase
        end
    end

    // MFHI/MFLO read path; reads the committed HI/LO even while busy
    always_comb begin
        w_hilo_rd  = 1'b0;
        w_hilo_out = {WIDTH{1'b0}};
        if ((bus.ALUOp == 4'b0000) && (bus.funct == F_MFHI)) begin
            w_hilo_rd  = 1'b1;
            w_hilo_out = r_hi;
        end else if ((bus.ALUOp == 4'b0000) && (bus.funct == F_MFLO)) begin
            w_hilo_rd  = 1'b1;
            w_hilo_out = r_lo;
        end else begin
            w_hilo_rd  = 1'b0;
            w_hilo_out = {WIDTH{1'b0}};
        end
    end

    // Iteration FSM and working registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= {CW{1'b0}};
            r_acc     <= {WIDTH{1'b0}};
            r_shf     <= {WIDTH{1'b0}};
            r_opb     <= {WIDTH{1'b0}};
            r_is_div  <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_dz_pend <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_dz_pend <= 1'b0;
                    if (w_accept && w_is_muldiv) begin
                        if (w_dz) begin
                            // Divide by zero stays idle; the dividend is parked
                            // in r_acc for the HI write on the next edge
                            r_dz_pend <= 1'b1;
                            r_acc     <= bus.op_a;
                        end else begin
                            r_state  <= S_RUN;
                            r_cnt    <= {CW{1'b0}};
                            r_acc    <= {WIDTH{1'b0}};
                            r_shf    <= f_mag(bus.op_a, w_is_signed);
                            r_opb    <= f_mag(bus.op_b, w_is_signed);
                            r_is_div <= bus.funct[1];
                            r_neg_q  <= w_is_signed & (bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1]);
                            r_neg_r  <= w_is_signed & bus.op_a[WIDTH-1];
                        end
                    end
                end
                S_RUN: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (r_is_div) begin
                        r_acc <= w_div_ge ? w_div_diff[WIDTH-1:0] : w_div_shift[WIDTH-1:0];
                        r_shf <= {r_shf[WIDTH-2:0], w_div_ge};
                    end else begin
                        r_acc <= w_mul_sum[WIDTH:1];
                        r_shf <= {w_mul_sum[0], r_shf[WIDTH-1:1]};
                    end
                    if (r_cnt == CW'(WIDTH-1)) begin
                        r_state <= S_FIN;
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                    r_cnt   <= {CW{1'b0}};
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_cnt     <= {CW{1'b0}};
                    r_dz_pend <= 1'b0;
                end
            endcase
        end
    end

    // Architectural HI/LO, completion pulse and divide-by-zero flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi       <= {WIDTH{1'b0}};
            r_lo       <= {WIDTH{1'b0}};
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == S_FIN) begin
                r_hi   <= w_res_hi;
                r_lo   <= w_res_lo;
                r_done <= 1'b1;
            end else begin
                if (r_dz_pend) begin
                    r_hi   <= r_acc;
                    r_lo   <= {WIDTH{1'b1}};
                    r_done <= 1'b1;
                end
                // A move issued right behind a divide-by-zero is younger, so it wins
                if (w_accept && (bus.funct == F_MTHI)) begin
                    r_hi <= bus.op_a;
                end
                if (w_accept && (bus.funct == F_MTLO)) begin
                    r_lo <= bus.op_a;
                end
            end
            if (w_accept && w_is_muldiv) begin
                r_div_zero <= 1'b0;
            end
            if (r_dz_pend) begin
                r_div_zero <= 1'b1;
            end
        end
    end

    assign bus.ALUControl = w_alu_ctrl;
    assign bus.illegal    = w_illegal;
    assign bus.hilo_rd    = w_hilo_rd;
    assign bus.hilo_out   = w_hilo_out;
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.done       = r_done;
    assign bus.div_zero   = r_div_zero;
    assign bus.hi         = r_hi;
    assign bus.lo         = r_lo;

endmodule

// File: tb/tb_ula_muldiv_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ula_muldiv_ctrl
// Directed vectors with hand-computed results. Each mul/div issue pushes its
// expected HI/LO/div_zero and completion cycle into a queue; a monitor pops
// and compares whenever done is seen.
// ---------------------------------------------------------------------------
module tb_ula_muldiv_ctrl;

    localparam int W = 32;

    typedef struct {
        int          cyc;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb[$];

    ula_muldiv_ctrl_if #(.WIDTH(W)) bus();

    ula_muldiv_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst_n && bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d expected no done", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("done_cycle", 64'(cyc), 64'(e.cyc));
                chk("hi", 64'(bus.hi), 64'(e.hi));
                chk("lo", 64'(bus.lo), 64'(e.lo));
                chk("div_zero", 64'(bus.div_zero), 64'(e.dz));
            end
        end
    end

    // Issue one instruction; accepted on the next rising edge
    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo, input logic edz,
                         input int lat, input bit track);
        bus.start = 1'b1;
        bus.ALUOp = 4'b0000;
        bus.funct = f;
        bus.op_a  = a;
        bus.op_b  = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.op_a  = 32'hDEADBEEF;
        bus.op_b  = 32'h0BADF00D;
        if (track) begin
            sb.push_back('{cyc + lat, ehi, elo, edz});
            chk("busy_after_accept", 64'(bus.busy), 64'(lat > 1));
        end
    endtask

    // Wait (bounded) for every outstanding result to be checked
    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 100) begin
            @(posedge clk);
            t++;
        end
        @(posedge clk); #1;
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain_timeout: got %0d pending results expected 0", sb.size());
            sb.delete();
        end
    endtask

    logic [5:0] dec_fn [14] = '{6'b000000, 6'b000010, 6'b000011, 6'b000100, 6'b000110,
                                6'b000111, 6'b100000, 6'b100010, 6'b100100, 6'b100101,
                                6'b100110, 6'b100111, 6'b101010, 6'b101011};
    logic [3:0] dec_fc [14] = '{4'b1001, 4'b1010, 4'b1101, 4'b0011, 4'b0100,
                                4'b0101, 4'b0010, 4'b0110, 4'b0000, 4'b0001,
                                4'b1011, 4'b1100, 4'b0111, 4'b1111};
    logic [3:0] op_in  [10] = '{4'b0100, 4'b0101, 4'b1000, 4'b1010, 4'b1011,
                                4'b1100, 4'b1101, 4'b1110, 4'b0111, 4'b0001};
    logic [3:0] op_out [10] = '{4'b0110, 4'b1000, 4'b0010, 4'b0111, 4'b1111,
                                4'b0000, 4'b0001, 4'b1011, 4'b0010, 4'b0010};
    logic [5:0] ex_fn  [5]  = '{6'b111111, 6'b000001, 6'b011000, 6'b010001, 6'b011011};
    logic       ex_ill [5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before 100000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.start = 1'b0;
        bus.ALUOp = 4'b0000;
        bus.funct = 6'b100000;
        bus.op_a  = 32'h0;
        bus.op_b  = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(bus.busy), 64'(0));
        chk("rst_done", 64'(bus.done), 64'(0));
        chk("rst_div_zero", 64'(bus.div_zero), 64'(0));
        chk("rst_hi", 64'(bus.hi), 64'(0));
        chk("rst_lo", 64'(bus.lo), 64'(0));
        rst_n = 1'b1;

        // Decode sweep
        for (int i = 0; i < 14; i++) begin
            @(posedge clk); #1;
            bus.ALUOp = 4'b0000;
            bus.funct = dec_fn[i];
            #1;
            chk("decode_rtype", 64'({bus.ALUControl, bus.illegal}), 64'({dec_fc[i], 1'b0}));
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            bus.ALUOp = op_in[i];
            bus.funct = 6'b111111;
            #1;
            chk("decode_aluop", 64'({bus.ALUControl, bus.illegal}), 64'({op_out[i], 1'b0}));
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            bus.ALUOp = 4'b0000;
            bus.funct = ex_fn[i];
            #1;
            chk("decode_extra", 64'({bus.ALUControl, bus.illegal}), 64'({4'b0010, ex_ill[i]}));
        end
        @(posedge clk); #1;
        bus.funct = 6'b100000;
        #1;
        chk("hilo_rd_add", 64'({bus.hilo_rd, bus.hilo_out}), 64'(0));

        // Multiply / divide vectors
        issue(6'b011000, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33, 1'b1); drain();
        issue(6'b011001, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, 1'b0, 33, 1'b1); drain();
        issue(6'b011011, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 33, 1'b1); drain();
        issue(6'b011010, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33, 1'b1); drain();
        issue(6'b011010, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 1'b0, 33, 1'b1); drain();
        issue(6'b011010, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0, 33, 1'b1); drain();
        issue(6'b011000, 32'hFFFFFFFC, 32'hFFFFFFFB, 32'h0, 32'd20, 1'b0, 33, 1'b1); drain();
        issue(6'b011010, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1'b1, 1, 1'b1); drain();
        chk("div_zero_held", 64'(bus.div_zero), 64'(1));
        issue(6'b011000, 32'd6, 32'd7, 32'h0, 32'd42, 1'b0, 33, 1'b1); drain();

        // MTLO / MFLO and MTHI / MFHI
        issue(6'b010011, 32'h1234, 32'h0, 32'h0, 32'h0, 1'b0, 0, 1'b0);
        chk("mtlo_lo", 64'(bus.lo), 64'(32'h1234));
        chk("mtlo_busy", 64'(bus.busy), 64'(0));
        bus.funct = 6'b010010;
        #1;
        chk("mflo", 64'({bus.hilo_rd, bus.hilo_out}), 64'({1'b1, 32'h1234}));
        @(posedge clk); #1;
        issue(6'b010001, 32'hABCD, 32'h0, 32'h0, 32'h0, 1'b0, 0, 1'b0);
        bus.funct = 6'b010000;
        #1;
        chk("mfhi", 64'({bus.hilo_rd, bus.hilo_out}), 64'({1'b1, 32'hABCD}));
        @(posedge clk); #1;

        // MFHI during busy returns old HI; a start while busy is ignored
        issue(6'b011001, 32'd3, 32'd5, 32'h0, 32'd15, 1'b0, 33, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        bus.funct = 6'b010000;
        #1;
        chk("mfhi_busy", 64'(bus.hilo_out), 64'(32'hABCD));
        bus.start = 1'b1;
        bus.funct = 6'b011011;
        bus.op_a  = 32'd100;
        bus.op_b  = 32'd7;
        repeat (3) @(posedge clk);
        #1;
        bus.start = 1'b0;
        drain();

        // Reset during a multiply aborts it
        issue(6'b011000, 32'd5, 32'd6, 32'h0, 32'h0, 1'b0, 0, 1'b0);
        repeat (9) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 64'(bus.busy), 64'(0));
        chk("abort_hilo", 64'({bus.hi, bus.lo}), 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        issue(6'b011000, 32'h12345678, 32'h10, 32'h1, 32'h23456780, 1'b0, 33, 1'b1); drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
